// File: rtl/mux_arb_n.sv
// -----------------------------------------------------------------------------
// mux_arb_n
//   N-input, W-bit selector with a registered output stage and valid/ready
//   handshakes on every input and on the output. Two runtime modes:
//     mode=0 : direct select. An out-of-range select falls back to the last
//              channel (N_IN-1).
//     mode=1 : round-robin arbitration, searching from the channel after the
//              last one that actually transferred.
//   One transfer per cycle is sustained when the consumer keeps Dout_ready
//   high, because the output register can drain and reload on the same edge.
//
// Optional build macro:
//   CHAN_ID_EN - adds output Dout_ch, the index of the channel that supplied
//                Dout, registered alongside Dout.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   synchronous active-low reset
//   Din        in   [N_IN-1:0][W-1:0] per-channel data
//   Din_valid  in   [N_IN-1:0] per-channel valid
//   Din_ready  out  [N_IN-1:0] per-channel accept (at most one bit set)
//   mode       in   0 = direct select, 1 = round-robin
//   select     in   [SEL_W-1:0] channel index for direct mode
//   Dout       out  [W-1:0] registered output data
//   Dout_valid out  output register holds data
//   Dout_ready in   consumer accept
//   xfer_cnt   out  [CNT_W-1:0] accepted input transfers, wraps
//   Dout_ch    out  [SEL_W-1:0] source channel of Dout (CHAN_ID_EN only)
// -----------------------------------------------------------------------------
module mux_arb_n #(
  parameter int N_IN  = 5,
  parameter int W     = 8,
  parameter int CNT_W = 16,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [N_IN-1:0][W-1:0]   Din,
  input  logic [N_IN-1:0]          Din_valid,
  output logic [N_IN-1:0]          Din_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select,
  output logic [W-1:0]             Dout,
  output logic                     Dout_valid,
  input  logic                     Dout_ready,
  output logic [CNT_W-1:0]         xfer_cnt
`ifdef CHAN_ID_EN
  ,
  output logic [SEL_W-1:0]         Dout_ch
`endif
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

  logic [W-1:0]     dout_q,     dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [SEL_W-1:0] last_gnt_q, last_gnt_d;
`ifdef CHAN_ID_EN
  logic [SEL_W-1:0] ch_q,       ch_d;
`endif

  logic             load_en;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_hit;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             xfer;

  // Output register is free, or is being drained by the consumer this cycle.
  assign load_en = !dout_vld_q || Dout_ready;

  // Direct-mode candidate with the default-to-last rule.
  always_comb begin
    if (int'(select) < N_IN) cand = select;
    else                     cand = LAST_CH;
  end

  // Round-robin search: offsets 1..N_IN from last_gnt, so last_gnt itself is
  // considered last and wins only if it is the sole valid channel.
  always_comb begin
    int j;
    rr_idx = '0;
    rr_hit = 1'b0;
    j      = 0;
    for (int k = 1; k <= N_IN; k++) begin
      j = int'(last_gnt_q) + k;
      if (j >= N_IN) j = j - N_IN;
      if (!rr_hit && Din_valid[j]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(j);
      end
    end
  end

  always_comb begin
    if (mode) begin
      gnt_idx = rr_idx;
      gnt_vld = rr_hit;
    end else begin
      gnt_idx = cand;
      gnt_vld = Din_valid[cand];
    end
  end

  // A grant always implies the granted channel is valid, so a ready bit is a
  // transfer. Reset masks the handshake so nothing is accepted while held.
  assign xfer = gnt_vld && load_en && Reset_n;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      Din_ready[i] = xfer && (int'(gnt_idx) == i);
    end
  end

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
`ifdef CHAN_ID_EN
    ch_d       = ch_q;
`endif
    if (xfer) begin
      dout_d     = Din[gnt_idx];
      dout_vld_d = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
`ifdef CHAN_ID_EN
      ch_d       = gnt_idx;
`endif
      // Direct-mode transfers leave the round-robin pointer alone.
      if (mode) last_gnt_d = gnt_idx;
    end else if (dout_vld_q && Dout_ready) begin
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      cnt_q      <= '0;
      last_gnt_q <= LAST_CH;
`ifdef CHAN_ID_EN
      ch_q       <= '0;
`endif
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
`ifdef CHAN_ID_EN
      ch_q       <= ch_d;
`endif
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_vld_q;
  assign xfer_cnt   = cnt_q;
`ifdef CHAN_ID_EN
  assign Dout_ch    = ch_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_n
//   Directed bench for mux_arb_n with N_IN=5, W=8, CNT_W=4. Each scenario task
//   drives stimulus and compares outputs against hand-computed values.
//   Build with CHAN_ID_EN defined to also exercise Dout_ch.
// -----------------------------------------------------------------------------
module tb_mux_arb_n;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int SW = 3;

  logic               Clk;
  logic               Reset_n;
  logic [N-1:0][W-1:0] Din;
  logic [N-1:0]       Din_valid;
  logic [N-1:0]       Din_ready;
  logic               mode;
  logic [SW-1:0]      select;
  logic [W-1:0]       Dout;
  logic               Dout_valid;
  logic               Dout_ready;
  logic [CW-1:0]      xfer_cnt;
`ifdef CHAN_ID_EN
  logic [SW-1:0]      Dout_ch;
`endif

  int checks = 0;
  int errors = 0;

  mux_arb_n #(.N_IN(N), .W(W), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Din        (Din),
    .Din_valid  (Din_valid),
    .Din_ready  (Din_ready),
    .mode       (mode),
    .select     (select),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .xfer_cnt   (xfer_cnt)
`ifdef CHAN_ID_EN
    ,
    .Dout_ch    (Dout_ch)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) Din[i] = 8'(8'h10 + i);
    Din_valid  = 5'b11111;
    mode       = 1'b0;
    select     = 3'd3;
    Dout_ready = 1'b1;
    Reset_n    = 1'b0;
    tick();
    tick();
    checks++;
    if (Dout !== 8'h00) begin
      errors++; $display("FAIL rst_dout: got %h expected 00", Dout);
    end
    checks++;
    if (Dout_valid !== 1'b0) begin
      errors++; $display("FAIL rst_dout_valid: got %b expected 0", Dout_valid);
    end
    checks++;
    if (xfer_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_cnt: got %0d expected 0", xfer_cnt);
    end
    checks++;
    if (Din_ready !== 5'b00000) begin
      errors++; $display("FAIL rst_din_ready: got %b expected 00000", Din_ready);
    end
`ifdef CHAN_ID_EN
    checks++;
    if (Dout_ch !== 3'd0) begin
      errors++; $display("FAIL rst_dout_ch: got %0d expected 0", Dout_ch);
    end
`endif
    Reset_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [CW-1:0] exp_cnt;
    #1;
    checks++;
    if (Din_ready !== 5'b01000) begin
      errors++; $display("FAIL dir_ready_first: got %b expected 01000", Din_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_cnt = CW'(k);
      checks++;
      if (Dout !== 8'h13) begin
        errors++; $display("FAIL dir_dout[%0d]: got %h expected 13", k, Dout);
      end
      checks++;
      if (Dout_valid !== 1'b1) begin
        errors++; $display("FAIL dir_valid[%0d]: got %b expected 1", k, Dout_valid);
      end
      checks++;
      if (xfer_cnt !== exp_cnt) begin
        errors++; $display("FAIL dir_cnt[%0d]: got %0d expected %0d", k, xfer_cnt, exp_cnt);
      end
      checks++;
      if (Din_ready !== 5'b01000) begin
        errors++; $display("FAIL dir_ready[%0d]: got %b expected 01000", k, Din_ready);
      end
`ifdef CHAN_ID_EN
      checks++;
      if (Dout_ch !== 3'd3) begin
        errors++; $display("FAIL dir_ch[%0d]: got %0d expected 3", k, Dout_ch);
      end
`endif
    end
  endtask

  task automatic test_out_of_range();
    select    = 3'd6;
    Din_valid = 5'b10000;
    #1;
    checks++;
    if (Din_ready !== 5'b10000) begin
      errors++; $display("FAIL oob_ready: got %b expected 10000", Din_ready);
    end
    tick();
    checks++;
    if (Dout !== 8'h14) begin
      errors++; $display("FAIL oob_dout: got %h expected 14", Dout);
    end
    checks++;
    if (xfer_cnt !== 4'd5) begin
      errors++; $display("FAIL oob_cnt: got %0d expected 5", xfer_cnt);
    end
`ifdef CHAN_ID_EN
    checks++;
    if (Dout_ch !== 3'd4) begin
      errors++; $display("FAIL oob_ch: got %0d expected 4", Dout_ch);
    end
`endif
    // Candidate channel 4 not valid: no grant, register drains, count holds.
    Din_valid = 5'b01000;
    #1;
    checks++;
    if (Din_ready !== 5'b00000) begin
      errors++; $display("FAIL nogrant_ready: got %b expected 00000", Din_ready);
    end
    tick();
    checks++;
    if (Dout_valid !== 1'b0) begin
      errors++; $display("FAIL nogrant_valid: got %b expected 0", Dout_valid);
    end
    checks++;
    if (Dout !== 8'h14) begin
      errors++; $display("FAIL nogrant_dout_hold: got %h expected 14", Dout);
    end
    checks++;
    if (xfer_cnt !== 4'd5) begin
      errors++; $display("FAIL nogrant_cnt: got %0d expected 5", xfer_cnt);
    end
  endtask

  task automatic test_round_robin();
    int order_a[7];
    int order_b[4];
    logic [N-1:0]  exp_rdy;
    logic [W-1:0]  exp_dat;
    logic [CW-1:0] exp_cnt;
    order_a = '{0, 1, 2, 3, 4, 0, 1};
    order_b = '{1, 3, 1, 3};
    mode       = 1'b1;
    Din_valid  = 5'b11111;
    Dout_ready = 1'b1;
    do_reset();
    #1;
    for (int k = 0; k < 7; k++) begin
      exp_rdy = N'(1 << order_a[k]);
      exp_dat = W'(8'h10 + order_a[k]);
      exp_cnt = CW'(k + 1);
      checks++;
      if (Din_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_all_ready[%0d]: got %b expected %b", k, Din_ready, exp_rdy);
      end
      tick();
      checks++;
      if (Dout !== exp_dat) begin
        errors++; $display("FAIL rr_all_dout[%0d]: got %h expected %h", k, Dout, exp_dat);
      end
      checks++;
      if (xfer_cnt !== exp_cnt) begin
        errors++; $display("FAIL rr_all_cnt[%0d]: got %0d expected %0d", k, xfer_cnt, exp_cnt);
      end
`ifdef CHAN_ID_EN
      checks++;
      if (int'(Dout_ch) !== order_a[k]) begin
        errors++; $display("FAIL rr_all_ch[%0d]: got %0d expected %0d", k, Dout_ch, order_a[k]);
      end
`endif
    end
    Din_valid = 5'b01010;
    do_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = N'(1 << order_b[k]);
      exp_dat = W'(8'h10 + order_b[k]);
      checks++;
      if (Din_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_sparse_ready[%0d]: got %b expected %b", k, Din_ready, exp_rdy);
      end
      tick();
      checks++;
      if (Dout !== exp_dat) begin
        errors++; $display("FAIL rr_sparse_dout[%0d]: got %h expected %h", k, Dout, exp_dat);
      end
`ifdef CHAN_ID_EN
      checks++;
      if (int'(Dout_ch) !== order_b[k]) begin
        errors++; $display("FAIL rr_sparse_ch[%0d]: got %0d expected %0d", k, Dout_ch, order_b[k]);
      end
`endif
    end
  endtask

  // Continues from round-robin state: Dout=13 from channel 3, count 4.
  task automatic test_backpressure();
    Din_valid  = 5'b11111;
    Dout_ready = 1'b0;
    #1;
    checks++;
    if (Din_ready !== 5'b00000) begin
      errors++; $display("FAIL bp_ready_first: got %b expected 00000", Din_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (Dout !== 8'h13) begin
        errors++; $display("FAIL bp_dout[%0d]: got %h expected 13", k, Dout);
      end
      checks++;
      if (Dout_valid !== 1'b1) begin
        errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, Dout_valid);
      end
      checks++;
      if (Din_ready !== 5'b00000) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected 00000", k, Din_ready);
      end
      checks++;
      if (xfer_cnt !== 4'd4) begin
        errors++; $display("FAIL bp_cnt[%0d]: got %0d expected 4", k, xfer_cnt);
      end
    end
    Dout_ready = 1'b1;
    #1;
    checks++;
    if (Din_ready !== 5'b10000) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 10000", Din_ready);
    end
    tick();
    checks++;
    if (Dout !== 8'h14) begin
      errors++; $display("FAIL bp_release_dout: got %h expected 14", Dout);
    end
    checks++;
    if (Dout_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release_valid: got %b expected 1", Dout_valid);
    end
    checks++;
    if (xfer_cnt !== 4'd5) begin
      errors++; $display("FAIL bp_release_cnt: got %0d expected 5", xfer_cnt);
    end
`ifdef CHAN_ID_EN
    checks++;
    if (Dout_ch !== 3'd4) begin
      errors++; $display("FAIL bp_release_ch: got %0d expected 4", Dout_ch);
    end
`endif
  endtask

  task automatic test_counter_wrap();
    mode       = 1'b0;
    select     = 3'd0;
    Din_valid  = 5'b11111;
    Dout_ready = 1'b1;
    do_reset();
    #1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (xfer_cnt !== 4'd15) begin
          errors++; $display("FAIL wrap_cnt15: got %0d expected 15", xfer_cnt);
        end
      end
      if (i == 16) begin
        checks++;
        if (xfer_cnt !== 4'd0) begin
          errors++; $display("FAIL wrap_cnt16: got %0d expected 0", xfer_cnt);
        end
      end
      if (i == 17) begin
        checks++;
        if (xfer_cnt !== 4'd1) begin
          errors++; $display("FAIL wrap_cnt17: got %0d expected 1", xfer_cnt);
        end
        checks++;
        if (Dout !== 8'h10) begin
          errors++; $display("FAIL wrap_dout: got %h expected 10", Dout);
        end
      end
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    Din        = '0;
    Din_valid  = '0;
    mode       = 1'b0;
    select     = '0;
    Dout_ready = 1'b0;
    test_reset();
    test_direct();
    test_out_of_range();
    test_round_robin();
    test_backpressure();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
